// File: rtl/dir_button_ctrl_pkg.sv
// Shared types and constants for the direction push-button controller.
package dir_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'b00,
    StPressDb   = 2'b01,
    StHeld      = 2'b10,
    StReleaseDb = 2'b11
  } state_e;

  localparam logic Y_UP   = 1'b1;
  localparam logic Y_DOWN = 1'b0;

endpackage

// File: rtl/dir_button_ctrl_if.sv
// Button input and direction/status outputs of the direction controller.
interface dir_button_ctrl_if;
  logic       btn;
  logic       Y;
  logic       press;
  logic       long_press;
  logic [1:0] state_dbg;

  modport master (
    output btn,
    input  Y,
    input  press,
    input  long_press,
    input  state_dbg
  );

  modport slave (
    input  btn,
    output Y,
    output press,
    output long_press,
    output state_dbg
  );
endinterface

// File: rtl/dir_button_ctrl_sync_chain.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/dir_button_ctrl.sv
// Debounced push-button to count-direction bit: short press toggles Y, long press forces Y up.
module dir_button_ctrl
  import dir_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned LONG_CYCLES     = 64
) (
  input logic               clk,
  input logic               rst,
  dir_button_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(LONG_CYCLES + 1);
  localparam logic [CNT_W-1:0] DbLast   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HoldMax  = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(LONG_CYCLES - 1);

  logic             btn_s;
  state_e           state_q;
  logic [CNT_W-1:0] db_cnt_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic             long_flag_q;
  logic             y_q;
  logic             press_q;
  logic             long_press_q;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (bus.btn),
    .q  (btn_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      db_cnt_q     <= '0;
      hold_cnt_q   <= '0;
      long_flag_q  <= 1'b0;
      y_q          <= Y_UP;
      press_q      <= 1'b0;
      long_press_q <= 1'b0;
    end else begin
      press_q      <= 1'b0;
      long_press_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (btn_s) begin
            state_q     <= StPressDb;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            long_flag_q <= 1'b0;
          end
        end
        StPressDb: begin
          if (!btn_s) begin
            state_q <= StIdle;
          end else if (db_cnt_q == DbLast) begin
            state_q  <= StHeld;
            db_cnt_q <= '0;
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end
        StHeld: begin
          if (!btn_s) begin
            state_q  <= StReleaseDb;
            db_cnt_q <= '0;
          end else if (hold_cnt_q < HoldMax) begin
            // Saturating at HoldMax gives exactly one long_press per press.
            hold_cnt_q <= hold_cnt_q + 1'b1;
            if (hold_cnt_q == HoldLast) begin
              long_press_q <= 1'b1;
              y_q          <= Y_UP;
              long_flag_q  <= 1'b1;
            end
          end
        end
        StReleaseDb: begin
          if (btn_s) begin
            state_q <= StHeld;
          end else if (db_cnt_q == DbLast) begin
            state_q <= StIdle;
            if (!long_flag_q) begin
              press_q <= 1'b1;
              y_q     <= ~y_q;
            end
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.Y          = y_q;
  assign bus.press      = press_q;
  assign bus.long_press = long_press_q;
  assign bus.state_dbg  = state_q;

endmodule
